arbitro_mux_8x32: RTL and testbench
===================================

Name: arbitro_mux_8x32

Overview:
- Round-robin scheduler that shares the single 8-bit input of the 8x32 byte-to-word packer between four byte-lane requesters.
- Grants are word-atomic: one lane owns the packer for exactly 4 consecutive bytes.
- The block drives the packer's data_in_8x32, valid_in_8x32 and selector_clk_4f byte-position signals, and pops bytes from the granted lane.
- Sits between the lane show-ahead FIFOs and the packer, in the clk_4f domain.

Parameters:
- NUM_REQ, 4, number of requesting lanes; fixed at 4 because grant_id is 2 bits.
- BYTES_PER_WORD, 4, bytes per grant; fixed at 4 to match the 2-bit selector_clk_4f.

Ports:
- clk_4f  input  1  byte-rate clock; all logic on the posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  req[i]=1: lane i holds at least 4 bytes.
- data_lanes  input  32  packed lane heads; lane i byte at [8i+7:8i], show-ahead (valid in the same cycle as its pop).
- pop  output  4  one-hot; pop[i]=1 consumes lane i's head byte this cycle.
- data_in_8x32  output  8  registered byte to the packer.
- valid_in_8x32  output  1  data_in_8x32 is valid.
- selector_clk_4f  output  2  byte position of data_in_8x32 inside the 32-bit word (0 = first byte).
- grant_id  output  2  lane that owns the current or last burst.
- busy  output  1  FSM is in BURST.

Behaviour:
- Reset (synchronous, active-high): all outputs 0; FSM=IDLE; byte_cnt=0; last_grant=3 so lane 0 has first priority.
- FSM states: IDLE, BURST.
- IDLE:
  - If req!=0: choose the first set bit scanning last_grant+1, +2, +3, +4 (mod 4).
  - Register the choice into grant_id, set byte_cnt=0, go to BURST.
  - pop stays 0 in the arbitration cycle.
- BURST, each cycle:
  - pop[grant_id]=1 (combinational from state and grant_id).
  - Next edge: data_in_8x32 <= data_lanes byte of grant_id; valid_in_8x32 <= 1; selector_clk_4f <= byte_cnt; byte_cnt <= byte_cnt+1 (wraps at 4).
- Burst end: on the byte_cnt==3 cycle, last_grant <= grant_id.
  - If req has any bit set, excluding the granted lane's req in that same cycle (its count is stale), arbitrate immediately with the updated pointer. Stay in BURST, byte_cnt=0: back-to-back words, no bubble.
  - Otherwise go to IDLE.
- In IDLE: valid_in_8x32 <= 0 on the next edge. data_in_8x32 and selector_clk_4f hold their last values.
- Latency:
  - From IDLE: req rise to first pop is 1 cycle; to first valid byte is 2 cycles.
  - Back-to-back bursts: valid stays high continuously with selector sequence 0,1,2,3,0,1,...
- Requester rules:
  - req may drop once the lane has been granted. The burst always completes all 4 bytes.
  - A req drop on a non-granted lane simply removes it from the next arbitration.
- All four req bits high: grant order 0,1,2,3,0,... Each lane gets exactly 1 of every 4 words.
- Reset asserted mid-burst: burst aborted, pop=0 in the reset cycle, outputs 0 on the next edge. A partial word is never completed; the packer is reset alongside.
- selector_clk_4f==3 with valid_in_8x32=1 marks a word boundary for the packer.

Optional Feature:
- Macro: ARBITRO_WORD_STATS_EN.
- Defined:
  - Extra output word_count [31:0]: four 8-bit saturating counters, lane i at [8i+7:8i].
  - Lane i's counter increments when that lane's burst completes (byte_cnt==3).
  - Counters saturate at 255 and clear on reset.
- Undefined: the port and the counters are absent; all other behaviour is identical.

Decomposition:
- Shared package arbitro_pkg holds:
  - constants NUM_REQ=4 and BYTES_PER_WORD=4;
  - FSM state encoding ST_IDLE=1'b0, ST_BURST=1'b1;
  - lane-id width LANE_W=2.
- One sub-module, rr_picker_4: purely combinational round-robin picker.
  - Inputs: req[3:0], last_grant[1:0].
  - Outputs: gnt_id[1:0], gnt_any.
  - Reused for the IDLE and burst-end arbitration.

Test Plan:
- Reset: hold reset=1 for 3 cycles with req=4'b1111.
  - Expect pop=0, valid_in_8x32=0, data_in_8x32=0, selector_clk_4f=0, grant_id=0, busy=0.
- Single lane: req=4'b0001, lane 0 supplies bytes 8'h01..8'h04.
  - Expect pop[0] high for 4 cycles, starting 1 cycle after req.
  - Output bytes 01,02,03,04 with selector 0,1,2,3; valid high exactly 4 cycles.
  - If req dropped, FSM returns to IDLE.
- Fairness: req=4'b1111 held for 16 words.
  - grant_id sequence 0,1,2,3 repeated 4 times.
  - valid_in_8x32 never drops after the first byte.
  - selector_clk_4f cycles 0..3 continuously.
- Pointer wrap: after a lane 3 grant, set req=4'b1001.
  - Next grant is lane 0, then lane 3.
  - After a lane 0 grant with req=4'b1001, next grant is lane 3.
- Reset mid-burst: assert reset on the cycle where selector_clk_4f=1.
  - Next edge: all outputs 0, FSM=IDLE.
  - After release with req=4'b0100, the grant goes to lane 2 starting at selector 0.
- ARBITRO_WORD_STATS_EN: 300 words on lane 1 only.
  - word_count[15:8]=255 (saturated); other fields 0; field clears after reset.

Source files
------------

// File: rtl/arbitro_pkg.sv
// Shared constants, FSM encoding and lane helpers for the arbitro_mux_8x32 round-robin byte scheduler.
package arbitro_pkg;

    localparam int NUM_REQ        = 4;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = 2;

    localparam logic [LANE_W-1:0] LAST_BYTE = LANE_W'(BYTES_PER_WORD - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_REQ - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    function automatic logic [NUM_REQ-1:0] laneOneHot(input logic [LANE_W-1:0] id);
        return NUM_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/rr_picker_4.sv
// Purely combinational 4-way round-robin picker: first set req bit after last_grant, wrapping.
module rr_picker_4
    import arbitro_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [LANE_W-1:0]  last_grant,
    output logic [LANE_W-1:0]  gnt_id,
    output logic               gnt_any
);

    logic [LANE_W-1:0] cand;

    // Scan farthest offset first so the nearest requester after last_grant overwrites and wins.
    always_comb begin
        gnt_id  = last_grant;
        gnt_any = 1'b0;
        cand    = last_grant;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = last_grant + LANE_W'(k);
            if (req[cand]) begin
                gnt_id  = cand;
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_mux_8x32.sv
// Word-atomic round-robin scheduler feeding four byte lanes into the 8x32 packer.
// Optional per-lane completed-word counters are enabled with ARBITRO_WORD_STATS_EN.
module arbitro_mux_8x32
    import arbitro_pkg::*;
(
    input  logic                  clk_4f,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [8*NUM_REQ-1:0]  data_lanes,
    output logic [NUM_REQ-1:0]    pop,
    output logic [7:0]            data_in_8x32,
    output logic                  valid_in_8x32,
    output logic [LANE_W-1:0]     selector_clk_4f,
    output logic [LANE_W-1:0]     grant_id,
    output logic                  busy
`ifdef ARBITRO_WORD_STATS_EN
    ,
    output logic [8*NUM_REQ-1:0]  word_count
`endif
);

    state_e            state_q, state_d;
    logic [LANE_W-1:0] grant_q, grant_d;
    logic [LANE_W-1:0] byteCnt_q, byteCnt_d;
    logic [LANE_W-1:0] lastGrant_q, lastGrant_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic [LANE_W-1:0] sel_q, sel_d;

    logic [NUM_REQ-1:0] pickReq;
    logic [LANE_W-1:0]  pickLast;
    logic [LANE_W-1:0]  pickId;
    logic               pickAny;

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            byteCnt_q   <= '0;
            lastGrant_q <= LAST_LANE;
            data_q      <= '0;
            valid_q     <= 1'b0;
            sel_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            byteCnt_q   <= byteCnt_d;
            lastGrant_q <= lastGrant_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            sel_q       <= sel_d;
        end
    end

    // At burst end the granted lane's req still counts bytes being popped, so it is masked out
    // and the just-finished lane becomes the pointer for the back-to-back pick.
    always_comb begin
        if (state_q == ST_BURST) begin
            pickReq  = req & ~laneOneHot(grant_q);
            pickLast = grant_q;
        end else begin
            pickReq  = req;
            pickLast = lastGrant_q;
        end
    end

    rr_picker_4 u_picker (
        .req        (pickReq),
        .last_grant (pickLast),
        .gnt_id     (pickId),
        .gnt_any    (pickAny)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        byteCnt_d   = byteCnt_q;
        lastGrant_d = lastGrant_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        sel_d       = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (pickAny) begin
                    grant_d   = pickId;
                    byteCnt_d = '0;
                    state_d   = ST_BURST;
                end
            end
            ST_BURST: begin
                data_d    = data_lanes[{grant_q, 3'b000} +: 8];
                valid_d   = 1'b1;
                sel_d     = byteCnt_q;
                byteCnt_d = byteCnt_q + 1'b1;
                if (byteCnt_q == LAST_BYTE) begin
                    lastGrant_d = grant_q;
                    byteCnt_d   = '0;
                    if (pickAny) begin
                        grant_d = pickId;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pop is gated by reset so an aborted burst consumes nothing in the reset cycle.
    always_comb begin
        pop             = '0;
        if (!reset && state_q == ST_BURST) begin
            pop = laneOneHot(grant_q);
        end
        busy            = (state_q == ST_BURST);
        data_in_8x32    = data_q;
        valid_in_8x32   = valid_q;
        selector_clk_4f = sel_q;
        grant_id        = grant_q;
    end

`ifdef ARBITRO_WORD_STATS_EN
    logic [7:0] wordCnt_q [NUM_REQ];
    logic       wordDone;

    assign wordDone = (state_q == ST_BURST) && (byteCnt_q == LAST_BYTE);

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wordCnt_q[i] <= '0;
            end
        end else if (wordDone && wordCnt_q[grant_q] != 8'hFF) begin
            wordCnt_q[grant_q] <= wordCnt_q[grant_q] + 8'd1;
        end
    end

    always_comb begin
        word_count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            word_count[8*i +: 8] = wordCnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_arbitro_mux_8x32.sv
// Scoreboard bench for arbitro_mux_8x32; lanes are modelled as show-ahead FIFOs whose req reflects >=4 bytes.
module tb_arbitro_mux_8x32;

    logic        clk_4f;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data_lanes;
    logic [3:0]  pop;
    logic [7:0]  data_in_8x32;
    logic        valid_in_8x32;
    logic [1:0]  selector_clk_4f;
    logic [1:0]  grant_id;
    logic        busy;
`ifdef ARBITRO_WORD_STATS_EN
    logic [31:0] word_count;
`endif

    typedef struct {
        logic [1:0] lane;
        logic [1:0] sel;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   loaded[4];
    int   consumed[4];
    int   expHead[4];
    int   total = 0;
    int   bad   = 0;
    bit   found;

    arbitro_mux_8x32 dut (
        .clk_4f          (clk_4f),
        .reset           (reset),
        .req             (req),
        .data_lanes      (data_lanes),
        .pop             (pop),
        .data_in_8x32    (data_in_8x32),
        .valid_in_8x32   (valid_in_8x32),
        .selector_clk_4f (selector_clk_4f),
        .grant_id        (grant_id),
`ifdef ARBITRO_WORD_STATS_EN
        .word_count      (word_count),
`endif
        .busy            (busy)
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    function automatic logic [7:0] laneByte(input int lane, input int k);
        return 8'((lane << 6) | ((k + 1) & 63));
    endfunction

    // Lane FIFO model: head byte shown ahead, req means at least one full word remains.
    always_comb begin
        data_lanes = '0;
        req        = '0;
        for (int i = 0; i < 4; i++) begin
            data_lanes[8*i +: 8] = laneByte(i, consumed[i]);
            req[i]               = (loaded[i] - consumed[i]) >= 4;
        end
    end

    always @(posedge clk_4f) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                if (pop[i] === 1'b1) consumed[i] <= consumed[i] + 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every valid byte must match the head of the scoreboard; grant is checked on word start.
    always @(negedge clk_4f) begin
        if (!reset && valid_in_8x32 === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_valid", {31'b0, valid_in_8x32}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("data", {24'b0, data_in_8x32}, {24'b0, e.data});
                checkOutput("sel", {30'b0, selector_clk_4f}, {30'b0, e.sel});
                if (e.sel == 2'd0) checkOutput("grant", {30'b0, grant_id}, {30'b0, e.lane});
            end
        end
    end

    task automatic tick();
        @(negedge clk_4f);
        #1;
    endtask

    task automatic applyStimulus(input int lane, input int nBytes);
        loaded[lane] = loaded[lane] + nBytes;
    endtask

    task automatic pushWord(input int lane);
        for (int b = 0; b < 4; b++) begin
            exp_t e;
            e.lane = 2'(lane);
            e.sel  = 2'(b);
            e.data = laneByte(lane, expHead[lane]);
            sb.push_back(e);
            expHead[lane]++;
        end
    endtask

    task automatic syncLanes();
        for (int i = 0; i < 4; i++) begin
            loaded[i]  = consumed[i];
            expHead[i] = consumed[i];
        end
        sb.delete();
    endtask

    task automatic resetDut();
        reset = 1'b1;
        tick();
        tick();
        syncLanes();
        reset = 1'b0;
        tick();
    endtask

    task automatic waitDrain(input string tag, input int budget);
        for (int c = 0; c < budget; c++) begin
            if (sb.size() == 0 && busy === 1'b0 && valid_in_8x32 === 1'b0) break;
            tick();
        end
        checkOutput({tag, "_drain"}, 32'(sb.size()), 32'd0);
        checkOutput({tag, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic waitValidSel(input logic [1:0] sel, input int budget);
        found = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (valid_in_8x32 === 1'b1 && selector_clk_4f === sel) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("wait_valid", {31'b0, found}, 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            loaded[i] = 4;
        end
        tick();
        tick();
        tick();
        checkOutput("rst_pop", {28'b0, pop}, 32'd0);
        checkOutput("rst_valid", {31'b0, valid_in_8x32}, 32'd0);
        checkOutput("rst_data", {24'b0, data_in_8x32}, 32'd0);
        checkOutput("rst_sel", {30'b0, selector_clk_4f}, 32'd0);
        checkOutput("rst_grant", {30'b0, grant_id}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        syncLanes();
        reset = 1'b0;
        tick();

        $display("[TB] single lane");
        applyStimulus(0, 4);
        pushWord(0);
        checkOutput("single_pop_arb", {28'b0, pop}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            checkOutput("single_pop", {28'b0, pop}, 32'h1);
        end
        tick();
        checkOutput("single_pop_end", {28'b0, pop}, 32'd0);
        waitDrain("single", 20);

        $display("[TB] fairness");
        resetDut();
        for (int i = 0; i < 4; i++) applyStimulus(i, 16);
        for (int w = 0; w < 16; w++) pushWord(w % 4);
        waitValidSel(2'd0, 10);
        for (int c = 0; c < 63; c++) begin
            tick();
            checkOutput("valid_cont", {31'b0, valid_in_8x32}, 32'd1);
        end
        waitDrain("fair", 20);

        $display("[TB] pointer wrap");
        applyStimulus(0, 8);
        applyStimulus(3, 4);
        pushWord(0);
        pushWord(3);
        pushWord(0);
        waitDrain("wrap", 40);

        $display("[TB] reset mid-burst");
        applyStimulus(1, 4);
        pushWord(1);
        waitValidSel(2'd1, 10);
        reset = 1'b1;
        #1;
        checkOutput("midrst_pop", {28'b0, pop}, 32'd0);
        tick();
        checkOutput("midrst_valid", {31'b0, valid_in_8x32}, 32'd0);
        checkOutput("midrst_data", {24'b0, data_in_8x32}, 32'd0);
        checkOutput("midrst_sel", {30'b0, selector_clk_4f}, 32'd0);
        checkOutput("midrst_grant", {30'b0, grant_id}, 32'd0);
        checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
        syncLanes();
        reset = 1'b0;
        tick();
        applyStimulus(2, 4);
        pushWord(2);
        waitDrain("after_rst", 20);

`ifdef ARBITRO_WORD_STATS_EN
        $display("[TB] word stats");
        resetDut();
        checkOutput("stats_rst", word_count, 32'd0);
        applyStimulus(1, 1200);
        for (int w = 0; w < 300; w++) pushWord(1);
        waitDrain("stats", 3000);
        checkOutput("stats_sat", word_count, 32'h0000FF00);
        resetDut();
        checkOutput("stats_clear", word_count, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
